// File: rtl/lvds_align_ctrl.sv
// Word-alignment sequencer for a single-lane LVDS 8b/10b receiver: waits for PLL
// lock, hunts for K28.5 via bit-slip, verifies comma periodicity, re-aligns on errors.
module lvds_align_ctrl #(
  parameter logic [9:0]  COMMA_N    = 10'b0011111010,
  parameter logic [9:0]  COMMA_P    = 10'b1100000101,
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned SEARCH_WIN = 256,
  parameter int unsigned SLIP_PULSE = 2,
  parameter int unsigned SLIP_WAIT  = 8,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned DEC_LAT    = 4,
  parameter int unsigned ERR_WIN    = 1024,
  parameter int unsigned ERR_THRESH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_locked,
  input  logic [9:0] rx_word,
  input  logic       code_err,
  output logic       rx_data_align,
  output logic       align_done,
  output logic [3:0] slip_cnt,
  output logic [2:0] align_state,
  output logic [7:0] realign_cnt
);

  localparam int unsigned CYC_MAX = (SETTLE_CYC > SEARCH_WIN) ? SETTLE_CYC : SEARCH_WIN;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned HIT_W   = $clog2(LOCK_CNT + 1);
  localparam int unsigned SUP_W   = $clog2(DEC_LAT + 1);
  localparam int unsigned WIN_W   = $clog2(ERR_WIN);
  localparam int unsigned ERR_W   = $clog2(ERR_THRESH + 1);

  localparam logic [CYC_W-1:0] CYC_ZERO    = CYC_W'(1'b0);
  localparam logic [CYC_W-1:0] CYC_ONE     = CYC_W'(1'b1);
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0] WIN_LAST    = CYC_W'(SEARCH_WIN - 1);
  localparam logic [CYC_W-1:0] PULSE_LAST  = CYC_W'(SLIP_PULSE - 1);
  localparam logic [CYC_W-1:0] WAIT_LAST   = CYC_W'(SLIP_WAIT - 1);
  localparam logic [HIT_W-1:0] HIT_ZERO    = HIT_W'(1'b0);
  localparam logic [HIT_W-1:0] HIT_ONE     = HIT_W'(1'b1);
  localparam logic [HIT_W-1:0] HIT_LAST    = HIT_W'(LOCK_CNT - 1);
  localparam logic [SUP_W-1:0] SUP_ZERO    = SUP_W'(1'b0);
  localparam logic [SUP_W-1:0] SUP_ONE     = SUP_W'(1'b1);
  localparam logic [SUP_W-1:0] SUP_LOAD    = SUP_W'(DEC_LAT);
  localparam logic [WIN_W-1:0] WIN_ZERO    = WIN_W'(1'b0);
  localparam logic [WIN_W-1:0] WIN_ONE     = WIN_W'(1'b1);
  localparam logic [WIN_W-1:0] WIN_END     = WIN_W'(ERR_WIN - 1);
  localparam logic [ERR_W-1:0] ERR_ZERO    = ERR_W'(1'b0);
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1'b1);
  localparam logic [ERR_W-1:0] ERR_LAST    = ERR_W'(ERR_THRESH - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    SEARCH    = 3'd2,
    SLIP      = 3'd3,
    SLIP_WT   = 3'd4,
    VERIFY    = 3'd5,
    ALIGNED   = 3'd6
  } state_t;

  function automatic logic is_comma(input logic [9:0] w);
    return (w == COMMA_N) || (w == COMMA_P);
  endfunction

  // slip_cnt counts modulo ten so it always reads as one decimal digit
  function automatic logic [3:0] slip_next(input logic [3:0] v);
    if (v >= 4'd9) begin
      return 4'd0;
    end else begin
      return v + 4'd1;
    end
  endfunction

  state_t             state_r;
  state_t             state_nx_s;
  logic               lock_meta_r;
  logic               lock_sync_r;
  logic               comma_r;
  logic [CYC_W-1:0]   cyc_r;
  logic [HIT_W-1:0]   hit_cnt_r;
  logic [SUP_W-1:0]   supp_r;
  logic [WIN_W-1:0]   win_r;
  logic [ERR_W-1:0]   err_cnt_r;
  logic [3:0]         slip_cnt_r;
  logic [7:0]         realign_cnt_r;
  logic               rx_data_align_r;
  logic               align_done_r;
  logic               state_chg_s;
  logic               err_event_s;
  logic               err_trip_s;

  assign state_chg_s = (state_nx_s != state_r);
  assign err_event_s = (state_r == ALIGNED) && code_err && (supp_r == SUP_ZERO);
  assign err_trip_s  = err_event_s && (err_cnt_r == ERR_LAST);

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= rx_locked;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Registered comma detect; FSM decisions lag rx_word by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comma_r <= 1'b0;
    end else begin
      comma_r <= is_comma(rx_word);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= WAIT_LOCK;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; lock loss overrides every state-local transition
  always_comb begin
    state_nx_s = state_r;
    if (!lock_sync_r) begin
      state_nx_s = WAIT_LOCK;
    end else begin
      case (state_r)
        WAIT_LOCK: state_nx_s = SETTLE;
        SETTLE: begin
          if (cyc_r == SETTLE_LAST) state_nx_s = SEARCH;
          else                      state_nx_s = SETTLE;
        end
        SEARCH: begin
          if (comma_r)                state_nx_s = VERIFY;
          else if (cyc_r == WIN_LAST) state_nx_s = SLIP;
          else                        state_nx_s = SEARCH;
        end
        SLIP: begin
          if (cyc_r == PULSE_LAST) state_nx_s = SLIP_WT;
          else                     state_nx_s = SLIP;
        end
        SLIP_WT: begin
          if (cyc_r == WAIT_LAST) state_nx_s = SEARCH;
          else                    state_nx_s = SLIP_WT;
        end
        VERIFY: begin
          if (comma_r) begin
            if (hit_cnt_r == HIT_LAST) state_nx_s = ALIGNED;
            else                       state_nx_s = VERIFY;
          end else if (cyc_r == WIN_LAST) begin
            state_nx_s = SLIP;
          end else begin
            state_nx_s = VERIFY;
          end
        end
        ALIGNED: begin
          if (err_trip_s) state_nx_s = SEARCH;
          else            state_nx_s = ALIGNED;
        end
        default: state_nx_s = WAIT_LOCK;
      endcase
    end
  end

  // Shared settle/word/pulse/wait counter; restarts on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_r <= CYC_ZERO;
    end else if (state_chg_s || (state_r == WAIT_LOCK) || (state_r == ALIGNED) ||
                 ((state_r == VERIFY) && comma_r)) begin
      cyc_r <= CYC_ZERO;
    end else begin
      cyc_r <= cyc_r + CYC_ONE;
    end
  end

  // Comma hit count while verifying periodicity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_r <= HIT_ZERO;
    end else if (state_nx_s != VERIFY) begin
      hit_cnt_r <= HIT_ZERO;
    end else if (state_r != VERIFY) begin
      hit_cnt_r <= HIT_ONE;
    end else if (comma_r) begin
      hit_cnt_r <= hit_cnt_r + HIT_ONE;
    end else begin
      hit_cnt_r <= hit_cnt_r;
    end
  end

  // Slip counter: bumps on SLIP entry, cleared whenever a fresh search begins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slip_cnt_r <= 4'd0;
    end else if ((state_nx_s == SLIP) && (state_r != SLIP)) begin
      slip_cnt_r <= slip_next(slip_cnt_r);
    end else if ((state_nx_s == SEARCH) && ((state_r == SETTLE) || (state_r == ALIGNED))) begin
      slip_cnt_r <= 4'd0;
    end else begin
      slip_cnt_r <= slip_cnt_r;
    end
  end

  // Decoder-latency suppression of code_err right after alignment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      supp_r <= SUP_ZERO;
    end else if ((state_nx_s == ALIGNED) && (state_r != ALIGNED)) begin
      supp_r <= SUP_LOAD;
    end else if ((state_r == ALIGNED) && (supp_r != SUP_ZERO)) begin
      supp_r <= supp_r - SUP_ONE;
    end else begin
      supp_r <= supp_r;
    end
  end

  // Error window: a wrap clears the count after the closing error is judged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_r     <= WIN_ZERO;
      err_cnt_r <= ERR_ZERO;
    end else if ((state_r != ALIGNED) || (state_nx_s != ALIGNED)) begin
      win_r     <= WIN_ZERO;
      err_cnt_r <= ERR_ZERO;
    end else if (win_r == WIN_END) begin
      win_r     <= WIN_ZERO;
      err_cnt_r <= ERR_ZERO;
    end else begin
      win_r     <= win_r + WIN_ONE;
      err_cnt_r <= err_cnt_r + (err_event_s ? ERR_ONE : ERR_ZERO);
    end
  end

  // Loss-of-alignment counter, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      realign_cnt_r <= 8'd0;
    end else if ((state_r == ALIGNED) && (state_nx_s == SEARCH) && (realign_cnt_r != 8'hFF)) begin
      realign_cnt_r <= realign_cnt_r + 8'd1;
    end else begin
      realign_cnt_r <= realign_cnt_r;
    end
  end

  // Registered status/control outputs, decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_align_r <= 1'b0;
      align_done_r    <= 1'b0;
    end else begin
      rx_data_align_r <= (state_nx_s == SLIP);
      align_done_r    <= (state_nx_s == ALIGNED);
    end
  end

  assign rx_data_align = rx_data_align_r;
  assign align_done    = align_done_r;
  assign slip_cnt      = slip_cnt_r;
  assign align_state   = state_r;
  assign realign_cnt   = realign_cnt_r;

endmodule

// File: tb/tb_lvds_align_ctrl.sv
// Self-checking bench for lvds_align_ctrl: scenario table, directed corner
// sequences and random stimulus against a countdown-style reference model.
module tb_lvds_align_ctrl;
  localparam logic [9:0] CN = 10'b0011111010;
  localparam logic [9:0] CP = 10'b1100000101;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_locked = 1'b0;
  logic [9:0] rx_word = 10'd0;
  logic       code_err = 1'b0;
  logic       rx_data_align;
  logic       align_done;
  logic [3:0] slip_cnt;
  logic [2:0] align_state;
  logic [7:0] realign_cnt;

  int checks = 0;
  int failures = 0;

  lvds_align_ctrl dut (
    .clk(clk), .rst(rst), .rx_locked(rx_locked), .rx_word(rx_word), .code_err(code_err),
    .rx_data_align(rx_data_align), .align_done(align_done), .slip_cnt(slip_cnt),
    .align_state(align_state), .realign_cnt(realign_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int target;
    int period;
    int max_cyc;
    int exp_done;
    int exp_slips;
    int exp_rises;
  } vec_t;
  vec_t tbl[6];

  // reference model: phase number plus remaining-cycle timers
  int m_s1, m_s2, m_comma, m_st, m_left, m_hits, m_slips, m_realign, m_supp, m_errs, m_win;
  // link environment: slip offset relative to the true word boundary
  int offset, rises, hi, rda_prev;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_comma = 0; m_st = 0; m_left = 0; m_hits = 0;
    m_slips = 0; m_realign = 0; m_supp = 0; m_errs = 0; m_win = 0;
  endtask

  task automatic go_slip();
    m_st = 3; m_left = 2; m_slips = (m_slips + 1) % 10;
  endtask

  task automatic model_step(input bit rl, input logic [9:0] w, input bit ce);
    int lock, cm, ev;
    lock = m_s2; cm = m_comma;
    m_s2 = m_s1; m_s1 = rl;
    m_comma = (w == CN || w == CP) ? 1 : 0;
    if (lock == 0) begin
      m_st = 0; m_hits = 0; m_errs = 0;
    end else begin
      case (m_st)
        0: begin m_st = 1; m_left = 64; end
        1: begin
          m_left--;
          if (m_left == 0) begin m_st = 2; m_left = 256; m_slips = 0; end
        end
        2: begin
          if (cm != 0) begin m_st = 5; m_hits = 1; m_left = 256; end
          else begin m_left--; if (m_left == 0) go_slip(); end
        end
        3: begin m_left--; if (m_left == 0) begin m_st = 4; m_left = 8; end end
        4: begin m_left--; if (m_left == 0) begin m_st = 2; m_left = 256; end end
        5: begin
          if (cm != 0) begin
            m_hits++;
            if (m_hits == 4) begin m_st = 6; m_supp = 4; m_errs = 0; m_win = 1024; m_hits = 0; end
            else m_left = 256;
          end else begin
            m_left--;
            if (m_left == 0) begin m_hits = 0; go_slip(); end
          end
        end
        6: begin
          ev = (ce && m_supp == 0) ? 1 : 0;
          if (m_supp > 0) m_supp--;
          m_errs += ev;
          if (m_errs >= 8) begin
            m_st = 2; m_left = 256; m_slips = 0; m_errs = 0;
            if (m_realign < 255) m_realign++;
          end else begin
            m_win--;
            if (m_win == 0) begin m_win = 1024; m_errs = 0; end
          end
        end
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic check_model();
    cmp("align_state", int'(align_state), m_st);
    cmp("align_done", int'(align_done), (m_st == 6) ? 1 : 0);
    cmp("rx_data_align", int'(rx_data_align), (m_st == 3) ? 1 : 0);
    cmp("slip_cnt", int'(slip_cnt), m_slips);
    cmp("realign_cnt", int'(realign_cnt), m_realign);
  endtask

  function automatic logic [9:0] filler();
    logic [9:0] f;
    f = 10'($urandom_range(0, 1023));
    if (f == CN || f == CP) f = f ^ 10'b0000000001;
    return f;
  endfunction

  function automatic logic [9:0] gen_word(input int tgt, input int per, input int k);
    if (offset == tgt && (k % per) == 0) return ((k / per) % 2 == 1) ? CP : CN;
    return filler();
  endfunction

  task automatic cyc(input bit rl, input logic [9:0] w, input bit ce);
    rx_locked = rl; rx_word = w; code_err = ce;
    @(posedge clk);
    model_step(rl, w, ce);
    @(negedge clk);
    check_model();
    if (rx_data_align) hi++;
    if (rx_data_align && rda_prev == 0) begin rises++; offset = (offset + 1) % 10; end
    rda_prev = rx_data_align ? 1 : 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_locked = 1'b0; rx_word = 10'd0; code_err = 1'b0;
    @(negedge clk);
    model_reset();
    check_model();
    cmp("reset_state", int'(align_state), 0);
    rst = 1'b0;
    offset = 0; rises = 0; hi = 0; rda_prev = 0;
  endtask

  task automatic run_row(input int idx);
    int k;
    do_reset();
    k = 0;
    for (int c = 0; c < tbl[idx].max_cyc; c++) begin
      if (tbl[idx].exp_done == 1 && align_done) break;
      cyc(1'b1, gen_word(tbl[idx].target, tbl[idx].period, k), 1'b0);
      k++;
    end
    cmp($sformatf("row%0d_done", idx), int'(align_done), tbl[idx].exp_done);
    if (tbl[idx].exp_slips >= 0) cmp($sformatf("row%0d_slip_cnt", idx), int'(slip_cnt), tbl[idx].exp_slips);
    if (tbl[idx].exp_rises >= 0) begin
      cmp($sformatf("row%0d_slip_pulses", idx), rises, tbl[idx].exp_rises);
      cmp($sformatf("row%0d_slip_high_cycles", idx), hi, 2 * tbl[idx].exp_rises);
    end
  endtask

  task automatic test_verify_miss();
    int seen_slip, seen_done;
    do_reset();
    for (int c = 0; c < 200 && align_state != 3'd2; c++) cyc(1'b1, filler(), 1'b0);
    cmp("verify_search_reached", int'(align_state), 2);
    cyc(1'b1, CN, 1'b0);
    cyc(1'b1, filler(), 1'b0);
    cmp("verify_entered", int'(align_state), 5);
    for (int c = 0; c < 8; c++) cyc(1'b1, filler(), 1'b0);
    cyc(1'b1, CP, 1'b0);
    seen_slip = 0; seen_done = 0;
    for (int c = 0; c < 300; c++) begin
      cyc(1'b1, filler(), 1'b0);
      if (align_state == 3'd3) seen_slip = 1;
      if (align_done) seen_done = 1;
    end
    cmp("verify_miss_slip", seen_slip, 1);
    cmp("verify_miss_no_done", seen_done, 0);
  endtask

  task automatic test_lock_drop();
    do_reset();
    for (int c = 0; c < 700 && align_state != 3'd3; c++) cyc(1'b1, filler(), 1'b0);
    cmp("lockdrop_in_slip", int'(align_state), 3);
    cmp("lockdrop_rda_high", int'(rx_data_align), 1);
    for (int c = 0; c < 3; c++) cyc(1'b0, filler(), 1'b0);
    cmp("lockdrop_state", int'(align_state), 0);
    cmp("lockdrop_rda", int'(rx_data_align), 0);
    cmp("lockdrop_slip_kept", int'(slip_cnt), 1);
  endtask

  task automatic test_errors();
    int k;
    bit ce;
    do_reset();
    k = 0;
    for (int c = 0; c < 600 && !align_done; c++) begin cyc(1'b1, gen_word(0, 10, k), 1'b0); k++; end
    cmp("err_aligned", int'(align_done), 1);
    // 4 suppressed errors, 7 counted ones, then the 8th on the window-closing cycle
    for (int j = 1; j <= 1024; j++) begin
      ce = (j <= 4) || ((j % 100) == 0 && j <= 700) || (j == 1024);
      cyc(1'b1, filler(), ce);
      if (j == 1023) begin
        cmp("err7_done", int'(align_done), 1);
        cmp("err7_state", int'(align_state), 6);
      end
    end
    cmp("err8_state", int'(align_state), 2);
    cmp("err8_done", int'(align_done), 0);
    cmp("err8_realign", int'(realign_cnt), 1);
    cmp("err8_slip_clr", int'(slip_cnt), 0);
    for (int c = 0; c < 800 && !align_done; c++) begin cyc(1'b1, gen_word(0, 10, k), 1'b0); k++; end
    cmp("realign_done", int'(align_done), 1);
    cmp("realign_hold", int'(realign_cnt), 1);
    rst = 1'b1;
    #1;
    cmp("arst_done", int'(align_done), 0);
    cmp("arst_rda", int'(rx_data_align), 0);
    cmp("arst_state", int'(align_state), 0);
    cmp("arst_slip", int'(slip_cnt), 0);
    cmp("arst_realign", int'(realign_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    int lk_off;
    logic [9:0] w;
    do_reset();
    lk_off = 0;
    for (int c = 0; c < 6000; c++) begin
      if (lk_off > 0) lk_off--;
      else if ($urandom_range(0, 499) == 0) lk_off = $urandom_range(1, 6);
      if ($urandom_range(0, 15) == 0) w = ($urandom_range(0, 1) == 1) ? CP : CN;
      else w = filler();
      cyc(lk_off == 0, w, $urandom_range(0, 59) == 0);
    end
  endtask

  initial begin
    tbl[0] = '{target: 0, period: 10,  max_cyc: 2000, exp_done: 1, exp_slips: 0,  exp_rises: 0};
    tbl[1] = '{target: 3, period: 10,  max_cyc: 3000, exp_done: 1, exp_slips: 3,  exp_rises: 3};
    tbl[2] = '{target: 1, period: 37,  max_cyc: 3000, exp_done: 1, exp_slips: 1,  exp_rises: 1};
    tbl[3] = '{target: 9, period: 5,   max_cyc: 4000, exp_done: 1, exp_slips: 9,  exp_rises: 9};
    tbl[4] = '{target: 0, period: 256, max_cyc: 3000, exp_done: 1, exp_slips: 0,  exp_rises: 0};
    tbl[5] = '{target: 0, period: 257, max_cyc: 3200, exp_done: 0, exp_slips: -1, exp_rises: -1};
    for (int i = 0; i < 6; i++) run_row(i);
    test_verify_miss();
    test_lock_drop();
    test_errors();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
